// File: rtl/rgb_stream_packer.sv
// Packs 24-bit RGB pixels into a 32-bit AXI4-Stream, little-endian by byte:
// four pixels become three words, with tuser marking start-of-frame and tlast end-of-line.
module rgb_stream_packer (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [7:0]  r,
    input  logic [7:0]  g,
    input  logic [7:0]  b,
    input  logic        valid,
    input  logic        sof,
    input  logic        eol,
    output logic        in_stream_ready,
    output logic [31:0] out_stream_tdata,
    output logic [3:0]  out_stream_tkeep,
    output logic        out_stream_tlast,
    input  logic        out_stream_tready,
    output logic        out_stream_tvalid,
    output logic        out_stream_tuser
);

    logic [1:0]  phase_r;
    logic [23:0] hold_r;
    logic        hold_sof_r;
    logic        pend_r;
    logic [31:0] pend_data_r;
    logic [31:0] tdata_r;
    logic        tvalid_r;
    logic        tlast_r;
    logic        tuser_r;

    logic [23:0] pix_s;
    logic        load_s;
    logic        accept_s;
    logic [1:0]  eff_phase_s;
    logic [1:0]  phase_nxt_s;
    logic        emit_s;
    logic [31:0] emit_data_s;
    logic        emit_last_s;
    logic        emit_user_s;
    logic        pend_s;
    logic [31:0] pend_data_s;

    assign out_stream_tdata  = tdata_r;
    assign out_stream_tvalid = tvalid_r;
    assign out_stream_tlast  = tlast_r;
    assign out_stream_tuser  = tuser_r;
    assign out_stream_tkeep  = 4'hF;

    // Handshake: an eol at phase 1/2 leaves a second word queued, which blocks input for one word slot.
    always_comb begin
        pix_s           = {r, g, b};
        load_s          = out_stream_tready || !tvalid_r;
        in_stream_ready = load_s && !pend_r;
        accept_s        = valid && in_stream_ready;
    end

    // Word assembly for the pixel being accepted; sof restarts the group at phase 0.
    always_comb begin
        eff_phase_s = sof ? 2'd0 : phase_r;
        phase_nxt_s = phase_r;
        emit_s      = 1'b0;
        emit_data_s = 32'h0000_0000;
        emit_last_s = 1'b0;
        emit_user_s = 1'b0;
        pend_s      = 1'b0;
        pend_data_s = 32'h0000_0000;
        case (eff_phase_s)
            2'd0: begin
                if (eol) begin
                    emit_s      = 1'b1;
                    emit_data_s = {8'h00, pix_s};
                    emit_last_s = 1'b1;
                    emit_user_s = sof;
                    phase_nxt_s = 2'd0;
                end else begin
                    phase_nxt_s = 2'd1;
                end
            end
            2'd1: begin
                emit_s      = 1'b1;
                emit_data_s = {pix_s[7:0], hold_r};
                emit_user_s = hold_sof_r;
                if (eol) begin
                    pend_s      = 1'b1;
                    pend_data_s = {16'h0000, pix_s[23:8]};
                    phase_nxt_s = 2'd0;
                end else begin
                    phase_nxt_s = 2'd2;
                end
            end
            2'd2: begin
                emit_s      = 1'b1;
                emit_data_s = {pix_s[15:0], hold_r[23:8]};
                if (eol) begin
                    pend_s      = 1'b1;
                    pend_data_s = {24'h00_0000, pix_s[23:16]};
                    phase_nxt_s = 2'd0;
                end else begin
                    phase_nxt_s = 2'd3;
                end
            end
            2'd3: begin
                emit_s      = 1'b1;
                emit_data_s = {pix_s, hold_r[23:16]};
                emit_last_s = eol;
                phase_nxt_s = 2'd0;
            end
            default: begin
                phase_nxt_s = 2'd0;
            end
        endcase
    end

    // Phase tracking, previous-pixel store and output register update.
    always_ff @(posedge aclk) begin
        if (aresetn) begin
            phase_r     <= 2'd0;
            hold_r      <= 24'h00_0000;
            hold_sof_r  <= 1'b0;
            pend_r      <= 1'b0;
            pend_data_r <= 32'h0000_0000;
            tdata_r     <= 32'h0000_0000;
            tvalid_r    <= 1'b0;
            tlast_r     <= 1'b0;
            tuser_r     <= 1'b0;
        end else begin
            if (accept_s) begin
                phase_r    <= phase_nxt_s;
                hold_r     <= pix_s;
                hold_sof_r <= sof;
            end
            if (load_s) begin
                if (pend_r) begin
                    tdata_r  <= pend_data_r;
                    tvalid_r <= 1'b1;
                    tlast_r  <= 1'b1;
                    tuser_r  <= 1'b0;
                    pend_r   <= 1'b0;
                end else if (accept_s && emit_s) begin
                    tdata_r     <= emit_data_s;
                    tvalid_r    <= 1'b1;
                    tlast_r     <= emit_last_s;
                    tuser_r     <= emit_user_s;
                    pend_r      <= pend_s;
                    pend_data_r <= pend_data_s;
                end else begin
                    tvalid_r <= 1'b0;
                    tlast_r  <= 1'b0;
                    tuser_r  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_rgb_stream_packer.sv
// Bench for rgb_stream_packer: byte-queue reference model checked every cycle,
// plus literal expectations for the documented word sequences.
module tb_rgb_stream_packer;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b1;
    logic [7:0]  r = 8'h00, g = 8'h00, b = 8'h00;
    logic        valid = 1'b0, sof = 1'b0, eol = 1'b0;
    logic        in_stream_ready;
    logic [31:0] out_stream_tdata;
    logic [3:0]  out_stream_tkeep;
    logic        out_stream_tlast;
    logic        out_stream_tready = 1'b1;
    logic        out_stream_tvalid;
    logic        out_stream_tuser;

    int vectors = 0;
    int miscompares = 0;

    // reference model: byte stream plus expected and observed word queues
    logic [7:0]  mb[$];
    bit          ms[$];
    bit          me[$];
    logic [31:0] ed[$];
    bit          el[$];
    bit          eu[$];
    logic [31:0] od[$];
    bit          ol[$];
    bit          ou[$];

    rgb_stream_packer dut (
        .aclk(aclk), .aresetn(aresetn), .r(r), .g(g), .b(b), .valid(valid),
        .sof(sof), .eol(eol), .in_stream_ready(in_stream_ready),
        .out_stream_tdata(out_stream_tdata), .out_stream_tkeep(out_stream_tkeep),
        .out_stream_tlast(out_stream_tlast), .out_stream_tready(out_stream_tready),
        .out_stream_tvalid(out_stream_tvalid), .out_stream_tuser(out_stream_tuser)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_emit();
        logic [31:0] d = 32'h0;
        bit l = 1'b0, u = 1'b0;
        for (int k = 0; k < 4; k++) begin
            d[8*k +: 8] = mb.pop_front();
            u = u | ms.pop_front();
            l = l | me.pop_front();
        end
        ed.push_back(d); el.push_back(l); eu.push_back(u);
    endtask

    task automatic model_push(input logic [23:0] p, input bit s, input bit e);
        if (s) begin
            mb.delete(); ms.delete(); me.delete();
        end
        for (int k = 0; k < 3; k++) begin
            mb.push_back(p[8*k +: 8]);
            ms.push_back(s && (k == 0));
            me.push_back(e && (k == 2));
        end
        while (mb.size() >= 4) model_emit();
        if (e && mb.size() > 0) begin
            while (mb.size() < 4) begin
                mb.push_back(8'h00); ms.push_back(1'b0); me.push_back(1'b0);
            end
            model_emit();
        end
    endtask

    // Compare process: outputs and handshakes sampled on the falling edge.
    always @(negedge aclk) begin
        if (aresetn) begin
            mb.delete(); ms.delete(); me.delete();
            ed.delete(); el.delete(); eu.delete();
        end else begin
            if (!out_stream_tvalid)
                chk("ready_idle", {31'h0, in_stream_ready}, 32'h1);
            else if (!out_stream_tready)
                chk("ready_hold", {31'h0, in_stream_ready}, 32'h0);
            if (out_stream_tvalid) begin
                chk("tkeep", {28'h0, out_stream_tkeep}, 32'hF);
                if (ed.size() == 0) begin
                    chk("unexpected_word", out_stream_tdata, 32'hxxxx_xxxx);
                end else begin
                    chk("tdata", out_stream_tdata, ed[0]);
                    chk("tlast", {31'h0, out_stream_tlast}, {31'h0, el[0]});
                    chk("tuser", {31'h0, out_stream_tuser}, {31'h0, eu[0]});
                    if (out_stream_tready) begin
                        void'(ed.pop_front()); void'(el.pop_front()); void'(eu.pop_front());
                        od.push_back(out_stream_tdata);
                        ol.push_back(out_stream_tlast);
                        ou.push_back(out_stream_tuser);
                    end
                end
            end
            if (valid && in_stream_ready)
                model_push({r, g, b}, sof, eol);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge aclk); #1;
        end
    endtask

    task automatic send(input logic [23:0] p, input bit s, input bit e);
        int n = 0;
        {r, g, b} = p; sof = s; eol = e; valid = 1'b1;
        @(negedge aclk);
        while (!in_stream_ready && n < 50) begin
            n++;
            @(negedge aclk);
        end
        if (!in_stream_ready) chk("send_timeout", 32'h0, 32'h1);
        @(posedge aclk); #1;
        valid = 1'b0; sof = 1'b0; eol = 1'b0;
    endtask

    task automatic chk_obs(input int i, input logic [31:0] d, input bit l, input bit u);
        if (i >= od.size()) begin
            chk("obs_missing", 32'h0, 32'h1);
        end else begin
            chk("obs_data", od[i], d);
            chk("obs_last", {31'h0, ol[i]}, {31'h0, l});
            chk("obs_user", {31'h0, ou[i]}, {31'h0, u});
        end
    endtask

    task automatic std4(input bit s, input bit e_last);
        send(24'h010203, s, 1'b0);
        send(24'h040506, 1'b0, 1'b0);
        send(24'h070809, 1'b0, 1'b0);
        send(24'h0A0B0C, 1'b0, e_last);
    endtask

    task automatic chk_std(input int base, input bit u, input bit l);
        chk_obs(base,     32'h0601_0203, 1'b0, u);
        chk_obs(base + 1, 32'h0809_0405, 1'b0, 1'b0);
        chk_obs(base + 2, 32'h0A0B_0C07, l,    1'b0);
    endtask

    initial begin
        int base;
        step(3);
        chk("rst_tvalid", {31'h0, out_stream_tvalid}, 32'h0);
        chk("rst_tdata", out_stream_tdata, 32'h0);
        chk("rst_tlast", {31'h0, out_stream_tlast}, 32'h0);
        chk("rst_tuser", {31'h0, out_stream_tuser}, 32'h0);
        chk("rst_tkeep", {28'h0, out_stream_tkeep}, 32'hF);
        chk("rst_ready", {31'h0, in_stream_ready}, 32'h1);
        aresetn = 1'b0;
        step(1);

        // basic group, no output after the first pixel
        base = od.size();
        send(24'h010203, 1'b1, 1'b0);
        chk("no_word_after_p0", {31'h0, out_stream_tvalid}, 32'h0);
        send(24'h040506, 1'b0, 1'b0);
        send(24'h070809, 1'b0, 1'b0);
        send(24'h0A0B0C, 1'b0, 1'b0);
        step(3);
        chk_std(base, 1'b1, 1'b0);

        // eol on the fourth pixel
        base = od.size();
        std4(1'b1, 1'b1);
        step(3);
        chk_std(base, 1'b1, 1'b1);

        // backpressure after word0
        base = od.size();
        send(24'h010203, 1'b1, 1'b0);
        send(24'h040506, 1'b0, 1'b0);
        out_stream_tready = 1'b0;
        {r, g, b} = 24'h070809; valid = 1'b1;
        step(4);
        chk("bp_tdata", out_stream_tdata, 32'h0601_0203);
        chk("bp_tvalid", {31'h0, out_stream_tvalid}, 32'h1);
        chk("bp_ready", {31'h0, in_stream_ready}, 32'h0);
        out_stream_tready = 1'b1;
        send(24'h070809, 1'b0, 1'b0);
        send(24'h0A0B0C, 1'b0, 1'b0);
        step(3);
        chk_std(base, 1'b1, 1'b0);
        chk("bp_count", od.size() - base, 32'd3);

        // input gaps
        base = od.size();
        send(24'h010203, 1'b1, 1'b0); step(2);
        send(24'h040506, 1'b0, 1'b0); step(2);
        chk("gap_tvalid_drop", {31'h0, out_stream_tvalid}, 32'h0);
        send(24'h070809, 1'b0, 1'b0); step(2);
        send(24'h0A0B0C, 1'b0, 1'b0); step(3);
        chk_std(base, 1'b1, 1'b0);

        // eol on the second pixel, then a fresh group from phase 0
        base = od.size();
        send(24'h010203, 1'b0, 1'b0);
        send(24'h040506, 1'b0, 1'b1);
        std4(1'b0, 1'b0);
        step(3);
        chk_obs(base,     32'h0601_0203, 1'b0, 1'b0);
        chk_obs(base + 1, 32'h0000_0405, 1'b1, 1'b0);
        chk_std(base + 2, 1'b0, 1'b0);

        // eol at phases 0 and 2, sof in mid-group (model-checked)
        send(24'hA1A2A3, 1'b1, 1'b1);
        send(24'hB1B2B3, 1'b0, 1'b0);
        send(24'hC1C2C3, 1'b0, 1'b0);
        send(24'hD1D2D3, 1'b0, 1'b1);
        send(24'hE1E2E3, 1'b0, 1'b0);
        send(24'hF1F2F3, 1'b0, 1'b0);
        send(24'h112233, 1'b1, 1'b0);
        send(24'h445566, 1'b0, 1'b0);
        send(24'h778899, 1'b0, 1'b1);
        step(4);

        // reset mid-group while a word is held
        send(24'h010203, 1'b1, 1'b0);
        send(24'h040506, 1'b0, 1'b0);
        out_stream_tready = 1'b0;
        step(1);
        aresetn = 1'b1;
        step(1);
        aresetn = 1'b0;
        chk("mid_rst_tvalid", {31'h0, out_stream_tvalid}, 32'h0);
        chk("mid_rst_tdata", out_stream_tdata, 32'h0);
        chk("mid_rst_ready", {31'h0, in_stream_ready}, 32'h1);
        out_stream_tready = 1'b1;
        base = od.size();
        std4(1'b0, 1'b0);
        step(3);
        chk_std(base, 1'b0, 1'b0);

        chk("model_drained", ed.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rgb_stream_packer.md
Name: rgb_stream_packer

Overview:
- Packs a stream of 24-bit RGB pixels into a 32-bit AXI4-Stream video output.
- Every 4 input pixels produce 3 output words.
- Sits between a pixel generator and the VDMA/video stream sink.
- Carries start-of-frame on tuser and end-of-line on tlast.

Parameters:
- None. Output width is fixed at 32 bits; pixel width is fixed at 24 bits.

Ports:
- aclk  in  1  clock; all logic is on the rising edge.
- aresetn  in  1  synchronous reset, active-high: 1 = reset asserted. The codebase port name is kept despite the polarity.
- r  in  8  pixel red.
- g  in  8  pixel green.
- b  in  8  pixel blue.
- valid  in  1  input pixel present.
- sof  in  1  current pixel is the first of a frame.
- eol  in  1  current pixel is the last of a line.
- in_stream_ready  out  1  packer can accept a pixel this cycle.
- out_stream_tdata  out  32  packed bytes.
- out_stream_tkeep  out  4  constant 4'hF.
- out_stream_tlast  out  1  end of line.
- out_stream_tready  in  1  downstream ready.
- out_stream_tvalid  out  1  output word valid.
- out_stream_tuser  out  1  start of frame.

Behaviour:
- Pixel word P = {r,g,b} (b in bits 7:0). Bytes enter the stream little-endian, lowest byte first.
- Pixel accept condition: accept = valid && in_stream_ready.
- in_stream_ready = out_stream_tready || !out_stream_tvalid (combinational).
- A 2-bit phase counter counts accepted pixels 0..3. It increments on each accept and wraps 3->0.
- Phase 0 accept: store P0; no output.
- Phase 1 accept: emit {P1[7:0], P0[23:0]}.
- Phase 2 accept: emit {P2[15:0], P1[23:8]}.
- Phase 3 accept: emit {P3[23:0], P2[23:16]}.
- Emit means the output registers load on the same clock edge. tdata/tvalid are visible one cycle after the accepting edge (latency 1).
- tuser is set on the word containing byte 0 of a pixel that arrived with sof = 1 (word0 of a group). Otherwise tuser is 0.
- tlast is set on the word carrying the last byte of a pixel that arrived with eol = 1.
- sof on an accept at phase != 0: the partial group is discarded and the sof pixel is taken as phase 0.
- eol on an accept at phase 0..2: emit the partial word immediately, with the unfilled upper bytes zero and tlast = 1. Phase then returns to 0.
- Output hold: while tvalid = 1 and tready = 0, tdata/tlast/tuser/tvalid stay stable and in_stream_ready = 0. Input pixels are ignored while in_stream_ready = 0.
- When tvalid && tready and no new word is emitted that edge, tvalid goes 0 on the next edge.
- Back-to-back accepts with tready = 1 continuously sustain 3 words per 4 pixels with no bubbles.
- Reset (aresetn = 1, synchronous), applied at any time including mid-group:
  - tvalid = 0, tlast = 0, tuser = 0, tdata = 0.
  - Phase = 0; the stored partial pixel is cleared.
  - in_stream_ready = 1 during and after reset (tvalid = 0).
  - tkeep = 4'hF always, including in reset.

Test Plan:
- Reset, then 4 pixels, tready = 1:
  - Inputs: valid = 1, sof on the first; P = 0x010203, 0x040506, 0x070809, 0x0A0B0C.
  - Required: 0x06010203 with tuser = 1, then 0x08090405, then 0x0A0B0C07 with tuser = 0. No output after the first pixel.
- Same 4 pixels with eol on the 4th -> only the 0x0A0B0C07 word has tlast = 1.
- Backpressure: hold tready = 0 after word0 is emitted.
  - Required: tdata stays 0x06010203 and tvalid stays 1; in_stream_ready = 0; pixels offered while ready is low are not consumed.
  - Release tready -> the sequence resumes unchanged.
- Input gaps: valid toggling 1/0 -> identical word sequence; tvalid drops to 0 between words.
- eol on the 2nd pixel (0x010203, 0x040506) -> one word 0x06010203 then 0x00000405 with tlast = 1; the next pixel starts phase 0.
- Reset mid-group after 2 pixels -> tvalid = 0 next cycle; 4 fresh pixels then produce the standard 3-word pattern from phase 0.
